rt_cnt_ctrl: RTL
================

Name: rt_cnt_ctrl

Overview:
- Command controller and round-robin arbiter that shares one 32-bit cycle counter (8-bit-slice, sync-clear, clock-enable type) between NREQ requesters.
- Requesters issue START / STOP / CLEAR / CAPTURE commands via req/gnt handshake.
- The block drives the counter's clock-enable and synchronous clear, returns captured values tagged with requester ID, and raises a compare-match pulse.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CW, 32, counter width
- IDW, 2, requester ID width = clog2(NREQ)

Ports:
- rt_i_clk  in  1  clock
- rt_i_rst_n  in  1  asynchronous, active-low reset
- rt_i_req  in  NREQ  per-requester command request, level
- rt_i_cmd  in  2*NREQ  per-requester command, 2 bits each: 00 START, 01 STOP, 10 CLEAR, 11 CAPTURE
- rt_o_gnt  out  NREQ  one-hot grant pulse
- rt_o_cnt_ce  out  1  counter clock enable
- rt_o_cnt_rst  out  1  counter synchronous clear, active high
- rt_i_cnt  in  CW  current counter value
- rt_i_cmp_en  in  1  compare enable
- rt_i_cmp_val  in  CW  compare value
- rt_o_cmp_hit  out  1  compare-match pulse
- rt_o_cap_vld  out  1  capture data valid pulse
- rt_o_cap_data  out  CW  captured count
- rt_o_cap_id  out  IDW  requester that issued the capture
- rt_o_run  out  1  counter running flag

Behaviour:
- Reset: all outputs 0, state STOP, RR pointer 0. Reset applied mid-operation aborts any pending grant; nothing is replayed after release.
- FSM has two states.
  - STOP: rt_o_cnt_ce=0. START moves to RUN.
  - RUN: rt_o_cnt_ce=1. STOP moves to STOP.
  - CLEAR and CAPTURE do not change state.
  - rt_o_run = (state==RUN), registered.
- Arbitration:
  - Combinational round-robin over eligible requests in cycle T.
  - Eligible = rt_i_req[i] and not granted in cycle T.
  - The winner's rt_o_gnt bit is registered high in T+1 for exactly one cycle.
  - The pointer moves to winner+1 (mod NREQ).
  - At most one grant per cycle.
  - The requester holds req and cmd stable until it sees gnt. It may keep req high for a new command, which re-arbitrates from T+2.
- Command effect (granted in T, gnt visible in T+1):
  - START / STOP: state updates at the end of T. rt_o_cnt_ce changes in T+1.
  - CLEAR: rt_o_cnt_rst high in T+1 for one cycle. The counter reads 0 in T+2. Run state is unchanged, so a running counter continues from 0 (clear has priority over ce in the counter).
  - CAPTURE: rt_o_cap_data <= rt_i_cnt sampled in T, and rt_o_cap_id <= winner. rt_o_cap_vld pulses in T+1, coincident with gnt. cap_data/cap_id hold until the next capture.
  - START while running and STOP while stopped are granted, with no effect.
- Compare:
  - rt_o_cmp_hit is registered. It pulses in T+1 when rt_i_cmp_en & rt_o_cnt_ce & (rt_i_cnt==rt_i_cmp_val) in T.
  - No pulse while stopped, even if the value matches.
  - Counter wrap 0xFFFFFFFF->0 is transparent; cmp_val 0 hits after the wrap.
- Simultaneous events:
  - A grant and a compare hit in the same cycle are independent.
  - CLEAR in the cycle the counter equals cmp_val still produces the hit pulse.

Optional Feature:
- Macro: RT_CNT_CTRL_AUTOSTOP_EN.
- Defined:
  - A compare match in cycle T gates rt_o_cnt_ce low combinationally in T, so the counter holds exactly cmp_val.
  - The state goes to STOP at the end of T.
  - A START granted in the same cycle T overrides: the state stays RUN, but ce is still gated in T.
- Undefined: a compare match only pulses rt_o_cmp_hit; the counter keeps running.

Decomposition:
- Package rt_cnt_pkg holds:
  - command encodings CMD_START/CMD_STOP/CMD_CLEAR/CMD_CAPTURE (2-bit)
  - state encodings ST_STOP/ST_RUN
  - default CW=32
- Sub-module rt_rr_arb (parameter NREQ): request and mask in; one-hot grant and pointer update out. It is reusable by other shared-resource blocks.

Test Plan:
- Reset, then req0=START: gnt[0] in T+1; ce=1 from T+1. After 10 cycles running, req1=CAPTURE: cap_vld=1, cap_id=1, cap_data=rt_i_cnt at the grant cycle.
- All four req high with CAPTURE from reset: grants in order 0,1,2,3, one per cycle, no repeat back-to-back; cap_id sequence 0,1,2,3.
- Running at count 0x1234, req2=CLEAR: cnt_rst pulse one cycle; counter 0 two cycles after the grant cycle; ce stays 1; run stays 1.
- cmp_en=1, cmp_val=0x00000005, START from 0: exactly one cmp_hit pulse, the cycle after the counter reads 5. STOP at 5, then hold for 5 cycles: no further pulses.
- Force the counter to 0xFFFFFFFE, cmp_val=0: hit after the wrap to 0.
- AUTOSTOP_EN defined, cmp_val=8, START: the counter stops and holds at 8, run=0, single hit pulse. With the macro undefined, the same stimulus gives a hit and the counter continues to 9.

Source files
------------

// File: rtl/rt_cnt_pkg.sv
// rt_cnt_pkg: shared definitions for the counter command controller.
//   cmd_t   : 2-bit requester command encoding
//   state_t : run/stop state of the shared counter
//   CW_DEF  : default counter width
package rt_cnt_pkg;

   localparam int CW_DEF = 32;

   typedef enum logic [1:0] {
      CMD_START   = 2'b00,
      CMD_STOP    = 2'b01,
      CMD_CLEAR   = 2'b10,
      CMD_CAPTURE = 2'b11
   } cmd_t;

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/rt_rr_arb.sv
// rt_rr_arb: combinational round-robin arbiter, reusable for any shared resource.
// The caller owns the pointer register and loads ptr_nxt when vld is high.
//   req     in  NREQ  request levels
//   mask    in  NREQ  requesters to skip this cycle (e.g. granted last cycle)
//   ptr     in  IDW   highest-priority requester
//   gnt     out NREQ  one-hot winner (all zero when nothing eligible)
//   vld     out 1     a winner exists
//   id      out IDW   winner index
//   ptr_nxt out IDW   winner+1 mod NREQ
module rt_rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] mask,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic            vld,
   output logic [IDW-1:0]  id,
   output logic [IDW-1:0]  ptr_nxt
);

   logic [NREQ-1:0] elig;
   int              off;
   int              best;

   assign elig = req & ~mask;

   // Priority is the distance from ptr going upward; smallest distance wins.
   always_comb begin
      gnt     = '0;
      vld     = 1'b0;
      id      = '0;
      ptr_nxt = ptr;
      off     = 0;
      best    = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         off = (i + NREQ - int'(ptr)) % NREQ;
         if (elig[i] && (off < best)) begin
            best    = off;
            gnt     = '0;
            gnt[i]  = 1'b1;
            vld     = 1'b1;
            id      = IDW'(i);
            ptr_nxt = IDW'((i + 1) % NREQ);
         end
      end
   end

endmodule

// File: rtl/rt_cnt_ctrl.sv
// rt_cnt_ctrl: command controller sharing one external cycle counter among
// NREQ requesters (START/STOP/CLEAR/CAPTURE over req/gnt), with compare-match.
//   rt_i_clk, rt_i_rst_n        clock, async active-low reset
//   rt_i_req / rt_i_cmd         per-requester request level and 2-bit command
//   rt_o_gnt                    one-cycle one-hot grant, one cycle after arbitration
//   rt_o_cnt_ce / rt_o_cnt_rst  counter enable / synchronous clear
//   rt_i_cnt                    current counter value
//   rt_i_cmp_en / rt_i_cmp_val  compare setup; rt_o_cmp_hit registered pulse
//   rt_o_cap_vld/_data/_id      capture result, data/id hold until next capture
//   rt_o_run                    counter running flag
// Build option: RT_CNT_CTRL_AUTOSTOP_EN stops the counter exactly on a compare match.
//
// state   | meaning
// ST_STOP | counter held, ce low
// ST_RUN  | counter enabled
module rt_cnt_ctrl
   import rt_cnt_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int CW   = CW_DEF,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              rt_i_clk,
   input  logic              rt_i_rst_n,
   input  logic [NREQ-1:0]   rt_i_req,
   input  logic [2*NREQ-1:0] rt_i_cmd,
   output logic [NREQ-1:0]   rt_o_gnt,
   output logic              rt_o_cnt_ce,
   output logic              rt_o_cnt_rst,
   input  logic [CW-1:0]     rt_i_cnt,
   input  logic              rt_i_cmp_en,
   input  logic [CW-1:0]     rt_i_cmp_val,
   output logic              rt_o_cmp_hit,
   output logic              rt_o_cap_vld,
   output logic [CW-1:0]     rt_o_cap_data,
   output logic [IDW-1:0]    rt_o_cap_id,
   output logic              rt_o_run
);

   state_t          state_q, state_nxt;
   logic [IDW-1:0]  ptr_q, ptr_nxt, win_id;
   logic [NREQ-1:0] win_gnt;
   logic            win_vld;
   cmd_t            win_cmd;
   logic            ce_run;
   logic            cmp_match;
   logic            do_clear;
   logic            do_capture;

   // Masking with last cycle's grant keeps a requester that has not yet
   // dropped req from being granted twice for the same command.
   rt_rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req     (rt_i_req),
      .mask    (rt_o_gnt),
      .ptr     (ptr_q),
      .gnt     (win_gnt),
      .vld     (win_vld),
      .id      (win_id),
      .ptr_nxt (ptr_nxt)
   );

   always_comb begin
      win_cmd = CMD_START;
      for (int i = 0; i < NREQ; i++) begin
         if (win_gnt[i]) win_cmd = cmd_t'(rt_i_cmd[2*i +: 2]);
      end
   end

   always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
      if (!rt_i_rst_n) state_q <= ST_STOP;
      else             state_q <= state_nxt;
   end

   always_comb begin
      state_nxt   = state_q;
      ce_run      = (state_q == ST_RUN);
      // Match is qualified by the ungated run state so the hit still fires
      // when autostop is what pulls ce low.
      cmp_match   = rt_i_cmp_en & ce_run & (rt_i_cnt == rt_i_cmp_val);
      rt_o_cnt_ce = ce_run;
      do_clear    = 1'b0;
      do_capture  = 1'b0;
`ifdef RT_CNT_CTRL_AUTOSTOP_EN
      if (cmp_match) begin
         rt_o_cnt_ce = 1'b0;
         state_nxt   = ST_STOP;
      end
`endif
      // A START granted alongside an autostop match wins the state, not ce.
      if (win_vld) begin
         case (win_cmd)
            CMD_START:   state_nxt  = ST_RUN;
            CMD_STOP:    state_nxt  = ST_STOP;
            CMD_CLEAR:   do_clear   = 1'b1;
            CMD_CAPTURE: do_capture = 1'b1;
            default:     ;
         endcase
      end
   end

   always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
      if (!rt_i_rst_n) begin
         ptr_q         <= '0;
         rt_o_gnt      <= '0;
         rt_o_cnt_rst  <= 1'b0;
         rt_o_cmp_hit  <= 1'b0;
         rt_o_cap_vld  <= 1'b0;
         rt_o_cap_data <= '0;
         rt_o_cap_id   <= '0;
         rt_o_run      <= 1'b0;
      end else begin
         rt_o_gnt     <= win_gnt;
         rt_o_cnt_rst <= do_clear;
         rt_o_cmp_hit <= cmp_match;
         rt_o_cap_vld <= do_capture;
         rt_o_run     <= (state_nxt == ST_RUN);
         if (win_vld) ptr_q <= ptr_nxt;
         if (do_capture) begin
            rt_o_cap_data <= rt_i_cnt;
            rt_o_cap_id   <= win_id;
         end
      end
   end

endmodule
